// File: rtl/led_xfade_pwm.sv
// Two-LED crossfader: PWM drive for a complementary duty pair that ramps
// one step every STEP_DIV clocks whenever the lit LED is swapped.
module led_xfade_pwm #(
    parameter int PWM_BITS = 8,
    parameter int STEP_DIV = 50000
) (
    input  logic                cloooock,
    input  logic                rst_n,
    input  logic                toggle,
    output logic                led1,
    output logic                led2,
    output logic [PWM_BITS-1:0] duty1,
    output logic                busy,
    output logic                done
);

    localparam logic [PWM_BITS-1:0] MAX = '1;
    localparam logic [PWM_BITS-1:0] ONE = PWM_BITS'(1);
    localparam int PSW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PSW-1:0] PLAST = PSW'(STEP_DIV - 1);

    typedef enum logic [1:0] {
        IDLE_L1,
        IDLE_L2,
        FADE_TO_L1,
        FADE_TO_L2
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty_nx;
    logic [PSW-1:0]      presc;
    logic [PSW-1:0]      presc_nx;
    logic                pend;
    logic                pend_nx;
    logic                done_nx;
    logic                fading;
    logic                step;

    function automatic logic pwm_bit(
        input logic [PWM_BITS-1:0] d,
        input logic [PWM_BITS-1:0] c
    );
        if (d == MAX) begin
            return 1'b1;
        end
        if (d == '0) begin
            return 1'b0;
        end
        return c < d;
    endfunction

    assign fading = (state == FADE_TO_L1) || (state == FADE_TO_L2);
    assign step   = fading && (presc == PLAST);
    assign busy   = fading;

    always_comb begin
        state_nx = state;
        duty_nx  = duty1;
        presc_nx = '0;
        pend_nx  = pend;
        done_nx  = 1'b0;
        unique case (state)
            IDLE_L1: begin
                if (toggle || pend) begin
                    state_nx = FADE_TO_L2;
                    pend_nx  = 1'b0;
                end
            end
            IDLE_L2: begin
                if (toggle || pend) begin
                    state_nx = FADE_TO_L1;
                    pend_nx  = 1'b0;
                end
            end
            FADE_TO_L1: begin
                pend_nx  = pend | toggle;
                presc_nx = step ? '0 : presc + 1'b1;
                if (step) begin
                    if (duty1 != MAX) begin
                        duty_nx = duty1 + ONE;
                    end
                    if (duty1 >= MAX - ONE) begin
                        state_nx = IDLE_L1;
                        done_nx  = 1'b1;
                    end
                end
            end
            FADE_TO_L2: begin
                pend_nx  = pend | toggle;
                presc_nx = step ? '0 : presc + 1'b1;
                if (step) begin
                    if (duty1 != '0) begin
                        duty_nx = duty1 - ONE;
                    end
                    if (duty1 <= ONE) begin
                        state_nx = IDLE_L2;
                        done_nx  = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE_L2;
        endcase
    end

    // LED 2 always runs the complementary duty of LED 1
    always_ff @(posedge cloooock or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE_L2;
            duty1   <= '0;
            pwm_cnt <= '0;
            presc   <= '0;
            pend    <= 1'b0;
            done    <= 1'b0;
            led1    <= 1'b0;
            led2    <= 1'b1;
        end else begin
            state   <= state_nx;
            duty1   <= duty_nx;
            presc   <= presc_nx;
            pend    <= pend_nx;
            done    <= done_nx;
            pwm_cnt <= pwm_cnt + ONE;
            led1    <= pwm_bit(duty1, pwm_cnt);
            led2    <= pwm_bit(MAX - duty1, pwm_cnt);
        end
    end

endmodule

// File: doc/led_xfade_pwm.md
LED_XFADE_PWM -- requirements
Module: led_xfade_pwm

Interface
REQ-001 SHALL have parameter PWM_BITS, default 8, giving the duty/PWM counter width (N), legal range 2..16.
REQ-002 SHALL have parameter STEP_DIV, default 50000, giving the clocks per duty step, legal range 1..2^24-1.
REQ-003 SHALL have port cloooock, input, 1 bit, the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset, synchronously deasserted externally.
REQ-005 SHALL have port toggle, input, 1 bit, single-cycle request pulse from the upstream blink stage asking to swap the lit LED.
REQ-006 SHALL have port led1, output, 1 bit, registered PWM drive for LED 1.
REQ-007 SHALL have port led2, output, 1 bit, registered PWM drive for LED 2.
REQ-008 SHALL have port duty1, output, N bits, current LED 1 duty (LED 2 duty = MAX - duty1, where MAX = 2^N-1).
REQ-009 SHALL have port busy, output, 1 bit, high while a crossfade is in progress.
REQ-010 SHALL have port done, output, 1 bit, one-cycle pulse when a crossfade completes.

Function
REQ-011 SHALL run an N-bit PWM counter that increments every clock and wraps MAX->0.
REQ-012 SHALL drive each LED as follows:
- duty == MAX: constant 1.
- duty == 0: constant 0.
- otherwise: (pwm_cnt < duty).
- Output is registered, 1 clock latency.
REQ-013 SHALL implement the states IDLE_L1, IDLE_L2, FADE_TO_L1 and FADE_TO_L2.
REQ-014 SHALL hold duty1 = MAX in IDLE_L1 and duty1 = 0 in IDLE_L2.
REQ-015 SHALL, on toggle=1 in IDLE_L2, enter FADE_TO_L1 on the next edge; on toggle=1 in IDLE_L1, enter FADE_TO_L2.
REQ-016 SHALL assert busy exactly when the state is FADE_TO_L1 or FADE_TO_L2.
REQ-017 SHALL clear the step prescaler (0..STEP_DIV-1) on fade entry, run it only in FADE states, and generate one step at each wrap.
REQ-018 SHALL, on each step, increment duty1 by 1 in FADE_TO_L1 and decrement it by 1 in FADE_TO_L2, saturating at MAX/0 with no wrap-around.
REQ-019 SHALL, on the step that makes duty1 reach MAX (or 0), enter IDLE_L1 (or IDLE_L2) on the same edge and pulse done for exactly that following cycle.
- Fade length is STEP_DIV*MAX clocks from entry.
REQ-020 SHALL, on toggle during a FADE state, set a 1-deep pending flag; further toggles while pending is set are dropped.
REQ-021 SHALL treat a toggle coinciding with the completing step as pending.
REQ-022 SHALL, when entering IDLE with pending set, start the reverse fade on the next edge, clear pending, and still emit done.
REQ-023 SHALL ignore toggle held high beyond one cycle as repeated requests only per REQ-015/REQ-020, with no level sensitivity.

Reset
REQ-024 SHALL, on rst_n=0, immediately and asynchronously set:
- state = IDLE_L2, duty1 = 0, pwm_cnt = 0, prescaler = 0, pending = 0.
- led1 = 0, led2 = 1, busy = 0, done = 0.
REQ-025 SHALL abort any fade in progress on reset mid-fade, with no done pulse.
REQ-026 SHALL ignore toggle in the first cycle after rst_n rises only if it arrives while rst_n=0.

Verification (PWM_BITS=4, STEP_DIV=4, MAX=15)
REQ-027 SHALL cover reset: rst_n low -> led1=0, led2=1, duty1=0, busy=0 immediately, without a clock edge.
REQ-028 SHALL cover a single fade: one toggle pulse in IDLE_L2 -> busy=1 next cycle, duty1 steps 0->15 every 4 clocks, done pulses once 60 clocks after fade entry, then state IDLE_L1 with led1 constant 1 and led2 constant 0.
REQ-029 SHALL cover PWM shape: at duty1=5 -> led1 high 5 of every 16 clocks and led2 high 10 of 16, 1 clock after counter.
REQ-030 SHALL cover queueing: toggle at fade cycle 10 and again at cycle 20 -> one reverse fade starts the cycle after done, duty1 returns 15->0, second toggle dropped, exactly two done pulses total.
REQ-031 SHALL cover a coincident toggle: toggle on the completing-step cycle -> treated as pending, reverse fade follows immediately.
REQ-032 SHALL cover reset mid-fade: rst_n low at duty1=7 -> duty1=0, busy=0, no done; toggle after release -> fresh fade from 0.
